soc_system_param_out: RTL and testbench

Avalon-MM write-side parameter port: the HPS writes a 16-bit value into a shadow register, and the block drives it onto `out_port`. Updates are committed atomically on a frame-sync rising edge, or immediately in immediate mode. A one-cycle `update_strobe` accompanies every change of `out_port`. It sits on the lightweight HPS-to-FPGA bridge next to the input PIO ports and feeds runtime thresholds (e.g. x/y window limits) into the video pipeline.

---
 rtl/soc_system_pio_pkg.sv | 12 +
 rtl/soc_system_edge_det.sv | 22 ++
 rtl/soc_system_param_out.sv | 126 ++++++++++++
 tb/tb_soc_system_param_out.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared register map for the HPS parameter/PIO ports on the lightweight bridge.
package soc_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_IMM_BIT    = 1;

endpackage

// File: rtl/soc_system_edge_det.sv
// Rising-edge detector: the input is registered once and the pulse is high
// while the input is high but was low on the previous clock.
module soc_system_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/soc_system_param_out.sv
// HPS-written parameter port: shadow register committed to out_port on a
// frame_sync rising edge or immediately. Optional macro SOC_SYSTEM_PARAM_OUT_READBACK_EN.
module soc_system_param_out
    import soc_system_pio_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic                  frame_sync,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  update_strobe
);

    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  pending_q, pending_d;
    logic                  imm_q, imm_d;
    logic                  strobe_q, strobe_d;
    logic [31:0]           rdata_q, rdata_d;

    logic fs_rise;
    logic wr_en;
    logic apply;
    logic imm_load;
    logic unused_wdata;

    assign unused_wdata = ^writedata;

    soc_system_edge_det u_fs_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_i   (frame_sync),
        .rise_o  (fs_rise)
    );

    assign wr_en    = chipselect & ~write_n;
    assign apply    = fs_rise & pending_q;
    assign imm_load = wr_en && (address == ADDR_DATA) && imm_q;

    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        imm_d     = imm_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        strobe_d  = imm_load | apply;

        // Apply reads the pre-edge shadow, so a same-cycle DATA write lands after it.
        if (apply) begin
            out_d     = shadow_q;
            pending_d = 1'b0;
        end
        if (imm_load) begin
            out_d = writedata[DATA_WIDTH-1:0];
        end
        if (strobe_d) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        if (wr_en) begin
            case (address)
                ADDR_DATA: shadow_d = writedata[DATA_WIDTH-1:0];
                ADDR_CTRL: begin
                    if (writedata[CTRL_COMMIT_BIT]) begin
                        pending_d = 1'b1;
                    end
                    imm_d = writedata[CTRL_IMM_BIT];
                end
                ADDR_COUNT: cnt_d = '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        case (address)
`ifdef SOC_SYSTEM_PARAM_OUT_READBACK_EN
            ADDR_DATA: rdata_d = 32'(out_q);
            ADDR_CTRL: rdata_d = 32'(shadow_q);
`else
            ADDR_DATA: rdata_d = '0;
            ADDR_CTRL: rdata_d = '0;
`endif
            ADDR_STATUS: begin
                rdata_d[CTRL_COMMIT_BIT] = pending_q;
                rdata_d[CTRL_IMM_BIT]    = imm_q;
            end
            ADDR_COUNT: rdata_d = 32'(cnt_q);
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q  <= '0;
            out_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            imm_q     <= 1'b0;
            strobe_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            shadow_q  <= shadow_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            imm_q     <= imm_d;
            strobe_q  <= strobe_d;
            rdata_q   <= rdata_d;
        end
    end

    assign readdata      = rdata_q;
    assign out_port      = out_q;
    assign update_strobe = strobe_q;

endmodule

// File: tb/tb_soc_system_param_out.sv
// Self-checking bench for soc_system_param_out with a transaction-level reference model.
module tb_soc_system_param_out;

`ifdef SOC_SYSTEM_PARAM_OUT_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic        frame_sync = 1'b0;
    logic [31:0] readdata;
    logic [15:0] out_port;
    logic        update_strobe;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, updated per transaction from the register rules.
    logic [15:0] m_shadow, m_out;
    bit          m_pend, m_imm, m_strobe, m_fs_prev;
    int          m_cnt;
    logic [31:0] m_rd;
    logic        fs_lvl;

    soc_system_param_out #(.DATA_WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .chipselect    (chipselect),
        .write_n       (write_n),
        .writedata     (writedata),
        .frame_sync    (frame_sync),
        .readdata      (readdata),
        .out_port      (out_port),
        .update_strobe (update_strobe)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_shadow = '0; m_out = '0; m_pend = 0; m_imm = 0;
        m_strobe = 0; m_fs_prev = 0; m_cnt = 0; m_rd = '0; fs_lvl = 1'b0;
    endtask

    // One bus cycle: drive inputs, clock, advance the model, settle past the edge.
    task automatic step(input logic cs, input logic wn, input logic [1:0] a,
                        input logic [31:0] wd, input logic fs);
        bit we, rise, do_apply, do_imm;
        logic [15:0] old_shadow;
        chipselect = cs; write_n = wn; address = a; writedata = wd; frame_sync = fs;
        @(posedge clk);
        we = cs && !wn;
        rise = fs && !m_fs_prev;
        case (a)
            2'd0: m_rd = RB ? {16'h0, m_out} : 32'h0;
            2'd1: m_rd = RB ? {16'h0, m_shadow} : 32'h0;
            2'd2: m_rd = {30'h0, m_imm, m_pend};
            default: m_rd = 32'(m_cnt);
        endcase
        old_shadow = m_shadow;
        do_apply = rise && m_pend;
        do_imm   = we && a == 2'd0 && m_imm;
        m_strobe = do_apply || do_imm;
        if (do_imm) m_out = wd[15:0];
        else if (do_apply) m_out = old_shadow;
        if (we && a == 2'd3) m_cnt = 0;
        else if (m_strobe) m_cnt = (m_cnt + 1) % 256;
        if (we && a == 2'd1 && wd[0]) m_pend = 1;
        else if (do_apply) m_pend = 0;
        if (we && a == 2'd1) m_imm = wd[1];
        if (we && a == 2'd0) m_shadow = wd[15:0];
        m_fs_prev = fs;
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        step(1'b1, 1'b0, a, wd, fs_lvl);
        $display("write addr=%0d data=0x%08h out_port=0x%04h strobe=%0b", a, wd, out_port, update_strobe);
    endtask

    task automatic rd(input logic [1:0] a);
        step(1'b1, 1'b1, a, 32'h0, fs_lvl);
        $display("read  addr=%0d readdata=0x%08h", a, readdata);
    endtask

    task automatic fs_set(input logic v);
        fs_lvl = v;
        step(1'b0, 1'b1, 2'd2, 32'h0, v);
        $display("frame_sync=%0b out_port=0x%04h strobe=%0b", v, out_port, update_strobe);
    endtask

    task automatic test_reset();
        wr(2'd0, 32'h0000_BEEF);
        wr(2'd1, 32'h1);
        fs_set(1'b1);
        reset_n = 1'b0;
        #2;
        model_reset();
        n_checks++;
        if (out_port !== 16'h0 || readdata !== 32'h0 || update_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: out=0x%04h rd=0x%08h strobe=%0b required 0/0/0",
                     out_port, readdata, update_strobe);
        end
        reset_n = 1'b1;
        fs_set(1'b0);
        rd(2'd3);
        n_checks++;
        if (readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_count: got 0x%08h required 0x00000000", readdata);
        end
    endtask

    task automatic test_deferred();
        wr(2'd0, 32'h0000_01F4);
        wr(2'd1, 32'h1);
        rd(2'd2);
        n_checks++;
        if (readdata !== 32'h1 || out_port !== 16'h0) begin
            n_fail++;
            $display("FAIL deferred_pending: status=0x%08h out=0x%04h required 0x1/0x0000", readdata, out_port);
        end
        fs_set(1'b1);
        n_checks++;
        if (out_port !== 16'h01F4 || update_strobe !== 1'b1) begin
            n_fail++;
            $display("FAIL deferred_apply: out=0x%04h strobe=%0b required 0x01f4/1", out_port, update_strobe);
        end
        fs_set(1'b1);
        n_checks++;
        if (update_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL deferred_single_pulse: strobe=%0b required 0", update_strobe);
        end
        fs_set(1'b0);
        rd(2'd2);
        n_checks++;
        if (readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL deferred_status_clear: got 0x%08h required 0x0", readdata);
        end
        rd(2'd3);
        n_checks++;
        if (readdata !== 32'h1) begin
            n_fail++;
            $display("FAIL deferred_count: got 0x%08h required 0x1", readdata);
        end
    endtask

    task automatic test_immediate();
        wr(2'd1, 32'h2);
        wr(2'd0, 32'h0000_0A5A);
        n_checks++;
        if (out_port !== 16'h0A5A || update_strobe !== 1'b1) begin
            n_fail++;
            $display("FAIL imm_load: out=0x%04h strobe=%0b required 0x0a5a/1", out_port, update_strobe);
        end
        rd(2'd3);
        n_checks++;
        if (readdata !== 32'h2 || update_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL imm_count: count=0x%08h strobe=%0b required 0x2/0", readdata, update_strobe);
        end
        fs_set(1'b1);
        n_checks++;
        if (out_port !== 16'h0A5A || update_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL imm_fs_noop: out=0x%04h strobe=%0b required 0x0a5a/0", out_port, update_strobe);
        end
        fs_set(1'b0);
        wr(2'd1, 32'h0);
    endtask

    task automatic test_collisions();
        wr(2'd0, 32'h0000_1111);
        wr(2'd1, 32'h1);
        fs_lvl = 1'b1;
        wr(2'd1, 32'h1);
        n_checks++;
        if (out_port !== 16'h1111 || update_strobe !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_commit_apply: out=0x%04h strobe=%0b required 0x1111/1", out_port, update_strobe);
        end
        rd(2'd2);
        n_checks++;
        if (readdata[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_commit_pending: status=0x%08h required bit0=1", readdata);
        end
        fs_set(1'b0);
        // pending is still set: shadow 1 then DATA write 2 colliding with apply
        wr(2'd0, 32'h0000_0001);
        fs_lvl = 1'b1;
        wr(2'd0, 32'h0000_0002);
        n_checks++;
        if (out_port !== 16'h0001) begin
            n_fail++;
            $display("FAIL coll_data_apply: out=0x%04h required 0x0001", out_port);
        end
        fs_set(1'b0);
        wr(2'd1, 32'h1);
        fs_set(1'b1);
        n_checks++;
        if (out_port !== 16'h0002) begin
            n_fail++;
            $display("FAIL coll_data_shadow: out=0x%04h required 0x0002", out_port);
        end
        fs_set(1'b0);
        wr(2'd1, 32'h1);
        fs_lvl = 1'b1;
        wr(2'd3, 32'h0);
        fs_set(1'b0);
        rd(2'd3);
        n_checks++;
        if (readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL coll_count_clear: got 0x%08h required 0x0", readdata);
        end
    endtask

    task automatic test_counter_wrap();
        int bad_strobes = 0;
        wr(2'd3, 32'h0);
        for (int i = 0; i < 257; i++) begin
            wr(2'd0, 32'(i));
            wr(2'd1, 32'h1);
            fs_set(1'b1);
            if (update_strobe !== 1'b1 || out_port !== 16'(i)) bad_strobes++;
            fs_set(1'b0);
            if (i == 255) begin
                rd(2'd3);
                n_checks++;
                if (readdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL count_wrap_256: got 0x%08h required 0x0", readdata);
                end
            end
        end
        rd(2'd3);
        n_checks++;
        if (readdata !== 32'h1) begin
            n_fail++;
            $display("FAIL count_wrap_257: got 0x%08h required 0x1", readdata);
        end
        n_checks++;
        if (bad_strobes != 0) begin
            n_fail++;
            $display("FAIL count_apply_loads: %0d bad applies required 0", bad_strobes);
        end
    endtask

    task automatic test_readback();
        wr(2'd0, 32'hFFFF_1234);
        wr(2'd1, 32'h1);
        rd(2'd1);
        n_checks++;
        if (readdata !== (RB ? 32'h0000_1234 : 32'h0)) begin
            n_fail++;
            $display("FAIL readback_shadow: got 0x%08h required 0x%08h", readdata, RB ? 32'h1234 : 32'h0);
        end
        rd(2'd0);
        n_checks++;
        if (readdata !== (RB ? {16'h0, m_out} : 32'h0)) begin
            n_fail++;
            $display("FAIL readback_data: got 0x%08h required 0x%08h", readdata, RB ? {16'h0, m_out} : 32'h0);
        end
        rd(2'd2);
        n_checks++;
        if (readdata !== 32'h1) begin
            n_fail++;
            $display("FAIL readback_status: got 0x%08h required 0x1", readdata);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        logic cs, wn, fs;
        logic [1:0] a;
        logic [31:0] wd;
        for (int i = 0; i < 400; i++) begin
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 1) != 0);
            a  = 2'($urandom_range(0, 3));
            wd = $urandom;
            if (a == 2'd3 && $urandom_range(0, 3) != 0) wn = 1'b1;
            fs = ($urandom_range(0, 2) == 0);
            step(cs, wn, a, wd, fs);
            $display("rand cs=%0b wn=%0b addr=%0d wd=0x%08h fs=%0b out=0x%04h strobe=%0b rd=0x%08h",
                     cs, wn, a, wd, fs, out_port, update_strobe, readdata);
            n_checks++;
            if (out_port !== m_out || update_strobe !== m_strobe || readdata !== m_rd) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_%0d: out=0x%04h strobe=%0b rd=0x%08h required 0x%04h/%0b/0x%08h",
                             i, out_port, update_strobe, readdata, m_out, m_strobe, m_rd);
            end
        end
        fs_lvl = fs;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        test_reset();
        test_deferred();
        test_immediate();
        test_collisions();
        test_counter_wrap();
        test_readback();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
